// File: rtl/fib_seq_checker.sv
// Fibonacci term-stream checker: accepts terms over valid/ready, verifies
// the recurrence, and reports done / overflow / mismatch with status.
module fib_seq_checker #(
    parameter int SIZE    = 4,
    parameter int N_TERMS = 16,
    parameter int CNT_W   = 5
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic             In_Valid,
    input  logic [SIZE-1:0]  In_Data,
    output logic             In_Ready,
    output logic             Done,
    output logic             Overflow,
    output logic             Error,
    output logic [CNT_W-1:0] Term_Count,
    output logic [SIZE-1:0]  Last_Value,
    output logic [SIZE-1:0]  Bad_Value,
    output logic [SIZE-1:0]  Expected
);

    typedef enum logic [2:0] {
        IDLE, FIRST, SECOND, RUN, DONE, ERR
    } state_e;

    state_e           state_q, state_d;
    logic [SIZE-1:0]  prev0_q, prev0_d;
    logic [SIZE-1:0]  prev1_q, prev1_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SIZE-1:0]  last_q, last_d;
    logic [SIZE-1:0]  bad_q, bad_d;
    logic [SIZE-1:0]  exp_q, exp_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;

    logic             accept;
    logic             mismatch;
    logic [SIZE:0]    sum;
    logic [SIZE:0]    next_sum;
    logic [CNT_W-1:0] cnt_inc;

    assign In_Ready = (state_q == FIRST) || (state_q == SECOND) ||
                      (state_q == RUN);
    assign accept   = In_Valid & In_Ready;
    assign sum      = {1'b0, prev0_q} + {1'b0, prev1_q};
    assign next_sum = {1'b0, (state_q == SECOND) ? prev0_q : prev1_q} +
                      {1'b0, In_Data};
    assign mismatch = (state_q == RUN) && ({1'b0, In_Data} != sum);
    assign cnt_inc  = cnt_q + CNT_W'(1);

    // State and datapath registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            prev0_q <= '0;
            prev1_q <= '0;
            cnt_q   <= '0;
            last_q  <= '0;
            bad_q   <= '0;
            exp_q   <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prev0_q <= prev0_d;
            prev1_q <= prev1_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            bad_q   <= bad_d;
            exp_q   <= exp_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    // Next state: Start wins, otherwise an accepted term advances the check.
    always_comb begin
        state_d = state_q;
        prev0_d = prev0_q;
        prev1_d = prev1_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        bad_d   = bad_q;
        exp_d   = exp_q;
        done_d  = done_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        if (Start) begin
            state_d = FIRST;
            prev0_d = '0;
            prev1_d = '0;
            cnt_d   = '0;
            last_d  = '0;
            bad_d   = '0;
            exp_d   = '0;
            done_d  = 1'b0;
            ovf_d   = 1'b0;
            err_d   = 1'b0;
        end else if (accept) begin
            cnt_d  = cnt_inc;
            last_d = In_Data;
            unique case (state_q)
                FIRST: begin
                    prev0_d = In_Data;
                    state_d = SECOND;
                end
                SECOND: begin
                    prev1_d = In_Data;
                    state_d = RUN;
                end
                RUN: begin
                    if (mismatch) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                        bad_d   = In_Data;
                        exp_d   = sum[SIZE-1:0];
                    end else begin
                        prev0_d = prev1_q;
                        prev1_d = In_Data;
                    end
                end
                default: ;
            endcase
            if (!mismatch) begin
                if (state_q != FIRST && next_sum[SIZE]) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    ovf_d   = 1'b1;
                end
                if (cnt_inc == CNT_W'(N_TERMS)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
        end
    end

    assign Done       = done_q;
    assign Overflow   = ovf_q;
    assign Error      = err_q;
    assign Term_Count = cnt_q;
    assign Last_Value = last_q;
    assign Bad_Value  = bad_q;
    assign Expected   = exp_q;

endmodule

// File: tb/tb_fib_seq_checker.sv
// Bench for fib_seq_checker: directed cases plus random streams, two
// instances (default N_TERMS and N_TERMS=5) checked against a term-history model.
module tb_fib_seq_checker;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic       Start = 1'b0;
    logic       In_Valid = 1'b0;
    logic [3:0] In_Data = '0;

    logic       a_rdy, a_done, a_ovf, a_err;
    logic [4:0] a_cnt;
    logic [3:0] a_last, a_bad, a_exp;
    logic       b_rdy, b_done, b_ovf, b_err;
    logic [4:0] b_cnt;
    logic [3:0] b_last, b_bad, b_exp;

    int n_chk = 0;
    int n_fail = 0;

    int hist [2][32];
    int m_cnt [2];
    int m_last [2];
    int m_bad [2];
    int m_exp [2];
    bit m_rdy [2];
    bit m_done [2];
    bit m_ovf [2];
    bit m_err [2];
    int nt [2] = '{16, 5};

    always #5 Clk = ~Clk;

    fib_seq_checker u_a (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start),
        .In_Valid(In_Valid), .In_Data(In_Data), .In_Ready(a_rdy),
        .Done(a_done), .Overflow(a_ovf), .Error(a_err),
        .Term_Count(a_cnt), .Last_Value(a_last),
        .Bad_Value(a_bad), .Expected(a_exp)
    );

    fib_seq_checker #(.N_TERMS(5)) u_b (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start),
        .In_Valid(In_Valid), .In_Data(In_Data), .In_Ready(b_rdy),
        .Done(b_done), .Overflow(b_ovf), .Error(b_err),
        .Term_Count(b_cnt), .Last_Value(b_last),
        .Bad_Value(b_bad), .Expected(b_exp)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear(int m, bit rdy);
        m_cnt[m]  = 0;
        m_last[m] = 0;
        m_bad[m]  = 0;
        m_exp[m]  = 0;
        m_done[m] = 0;
        m_ovf[m]  = 0;
        m_err[m]  = 0;
        m_rdy[m]  = rdy;
    endtask

    task automatic model_accept(int m, int v);
        int c;
        hist[m][m_cnt[m]] = v;
        m_cnt[m]++;
        m_last[m] = v;
        c = m_cnt[m];
        if (c >= 3 && v != hist[m][c-3] + hist[m][c-2]) begin
            m_err[m] = 1;
            m_bad[m] = v;
            m_exp[m] = (hist[m][c-3] + hist[m][c-2]) % 16;
            m_rdy[m] = 0;
        end else begin
            if (c >= 2 && hist[m][c-2] + hist[m][c-1] > 15) begin
                m_done[m] = 1;
                m_ovf[m]  = 1;
            end
            if (c == nt[m]) m_done[m] = 1;
            if (m_done[m]) m_rdy[m] = 0;
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, ".a.rdy"},  a_rdy,  m_rdy[0]);
        chk({tag, ".a.done"}, a_done, m_done[0]);
        chk({tag, ".a.ovf"},  a_ovf,  m_ovf[0]);
        chk({tag, ".a.err"},  a_err,  m_err[0]);
        chk({tag, ".a.cnt"},  a_cnt,  m_cnt[0]);
        chk({tag, ".a.last"}, a_last, m_last[0]);
        chk({tag, ".a.bad"},  a_bad,  m_bad[0]);
        chk({tag, ".a.exp"},  a_exp,  m_exp[0]);
        chk({tag, ".b.rdy"},  b_rdy,  m_rdy[1]);
        chk({tag, ".b.done"}, b_done, m_done[1]);
        chk({tag, ".b.ovf"},  b_ovf,  m_ovf[1]);
        chk({tag, ".b.err"},  b_err,  m_err[1]);
        chk({tag, ".b.cnt"},  b_cnt,  m_cnt[1]);
        chk({tag, ".b.last"}, b_last, m_last[1]);
        chk({tag, ".b.bad"},  b_bad,  m_bad[1]);
        chk({tag, ".b.exp"},  b_exp,  m_exp[1]);
    endtask

    task automatic step(string tag, bit s, bit v, int d);
        Start    = s;
        In_Valid = v;
        In_Data  = 4'(d);
        for (int m = 0; m < 2; m++) begin
            if (s) model_clear(m, 1);
            else if (v && m_rdy[m]) model_accept(m, d);
        end
        @(posedge Clk);
        #1;
        Start    = 1'b0;
        In_Valid = 1'b0;
        check_all(tag);
    endtask

    int fib8 [8] = '{0, 1, 1, 2, 3, 5, 8, 13};
    int bad5 [5] = '{0, 1, 1, 2, 4};
    int seq5 [5] = '{1, 1, 2, 3, 5};

    initial begin
        model_clear(0, 0);
        model_clear(1, 0);
        #2;
        check_all("reset");
        #10 Rst_n = 1'b1;
        @(posedge Clk);
        #1;

        // In_Valid while idle is ignored
        for (int i = 0; i < 3; i++) step("idle", 0, 1, 7);
        chk("idle.cnt", a_cnt, 0);

        // Case 1
        step("c1.start", 1, 0, 0);
        for (int i = 0; i < 8; i++) step("c1", 0, 1, fib8[i]);
        chk("c1.done", a_done, 1);
        chk("c1.ovf", a_ovf, 1);
        chk("c1.cnt", a_cnt, 8);
        chk("c1.last", a_last, 13);
        chk("c1.rdy", a_rdy, 0);
        step("c1.hold", 0, 1, 5);

        // Case 2
        step("c2.start", 1, 0, 0);
        for (int i = 0; i < 5; i++) step("c2", 0, 1, bad5[i]);
        chk("c2.err", a_err, 1);
        chk("c2.bad", a_bad, 4);
        chk("c2.exp", a_exp, 3);
        chk("c2.cnt", a_cnt, 5);
        chk("c2.done", a_done, 0);
        for (int i = 0; i < 3; i++) step("c2.ign", 0, 1, 9);

        // Case 3: N_TERMS=5 instance
        step("c3.start", 1, 0, 0);
        for (int i = 0; i < 5; i++) step("c3", 0, 1, seq5[i]);
        chk("c3.done", b_done, 1);
        chk("c3.ovf", b_ovf, 0);
        chk("c3.cnt", b_cnt, 5);
        chk("c3.last", b_last, 5);

        // Case 4: case 1 with random gaps
        step("c4.start", 1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 3)) step("c4.gap", 0, 0, 0);
            step("c4", 0, 1, fib8[i]);
        end
        chk("c4.done", a_done, 1);
        chk("c4.cnt", a_cnt, 8);

        // Case 5: Start with a simultaneous transfer
        step("c5.start", 1, 0, 0);
        for (int i = 0; i < 3; i++) step("c5", 0, 1, fib8[i]);
        step("c5.restart", 1, 1, 6);
        chk("c5.cnt", a_cnt, 0);
        step("c5.s0", 0, 1, 2);
        step("c5.s1", 0, 1, 3);
        step("c5.t", 0, 1, 5);
        chk("c5.cnt3", a_cnt, 3);
        chk("c5.err", a_err, 0);

        // Case 6: async reset mid-run
        step("c6.start", 1, 0, 0);
        for (int i = 0; i < 4; i++) step("c6", 0, 1, fib8[i]);
        #2 Rst_n = 1'b0;
        model_clear(0, 0);
        model_clear(1, 0);
        #1;
        check_all("c6.rst");
        #3 Rst_n = 1'b1;
        @(posedge Clk);
        #1;
        step("c6.ign0", 0, 1, 3);
        step("c6.ign1", 0, 1, 5);
        step("c6.restart", 1, 0, 0);
        step("c6.s0", 0, 1, 1);

        // Random streams: mostly correct continuations, some corrupt
        for (int s = 0; s < 20; s++) begin
            step("rnd.start", 1, 0, 0);
            for (int k = 0; k < 18; k++) begin
                int d;
                int c;
                c = m_cnt[0];
                if (c < 2) d = $urandom_range(0, 3);
                else if ($urandom_range(0, 5) != 0)
                    d = (hist[0][c-1] + hist[0][c-2]) % 16;
                else d = $urandom_range(0, 15);
                if ($urandom_range(0, 3) == 0) step("rnd.gap", 0, 0, 0);
                step("rnd", 0, 1, d);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
